tx_char_sched: RTL and testbench

- Character-level transmit controller for the IEEE-1355 DS link.
- Sits between the link-state FSM / transmit FIFO and the DS transmitter PHY, which takes Tx1, Tx0 and TxReset.
- Arbitrates between FCT, data/EOP and NULL characters, and tracks peer flow-control credit.
- Serialises each character into one Tx1/Tx0 bit per TxClk with odd parity.

---
 rtl/tx_char_pkg.sv | 75 +++++++
 rtl/tx_char_sched_if.sv | 31 +++
 rtl/tx_credit_ctr.sv | 63 ++++++
 rtl/tx_char_sched.sv | 159 +++++++++++++++
 tb/tb_tx_char_sched.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_char_pkg.sv
// Shared definitions for the DS-link character scheduler: control codes,
// character lengths, character kinds and the character builder with parity.
package tx_char_pkg;

  // Control codes are stored with bit 0 as the first bit on the wire.
  localparam logic [1:0] CODE_FCT  = 2'b00;
  localparam logic [1:0] CODE_EOP1 = 2'b10;
  localparam logic [1:0] CODE_EOP2 = 2'b01;
  localparam logic [1:0] CODE_ESC  = 2'b11;

  localparam logic [3:0] CTRL_LEN = 4'd4;
  localparam logic [3:0] DATA_LEN = 4'd10;
  localparam logic [3:0] NULL_LEN = 4'd8;

  typedef enum logic [2:0] {
    CH_NONE = 3'd0,
    CH_FCT  = 3'd1,
    CH_DATA = 3'd2,
    CH_EOP  = 3'd3,
    CH_NULL = 3'd4
  } ch_kind_e;

  typedef struct packed {
    logic [9:0] bits;
    logic [3:0] len;
    logic       hist;
  } char_t;

  function automatic logic odd_parity(input logic hist, input logic flag);
    return ~(hist ^ flag);
  endfunction

  function automatic logic [3:0] ctrl_bits(input logic hist, input logic [1:0] code);
    return {code, 1'b1, odd_parity(hist, 1'b1)};
  endfunction

  // hist is the XOR of the previous character's data/code bits.
  function automatic char_t build_char(input ch_kind_e kind, input logic [8:0] word,
                                       input logic hist);
    char_t      c;
    logic [1:0] eop_code;
    c.bits   = 10'd0;
    c.len    = 4'd0;
    c.hist   = hist;
    eop_code = word[0] ? CODE_EOP2 : CODE_EOP1;
    case (kind)
      CH_FCT: begin
        c.bits = {6'd0, ctrl_bits(hist, CODE_FCT)};
        c.len  = CTRL_LEN;
        c.hist = ^CODE_FCT;
      end
      CH_EOP: begin
        c.bits = {6'd0, ctrl_bits(hist, eop_code)};
        c.len  = CTRL_LEN;
        c.hist = ^eop_code;
      end
      CH_DATA: begin
        c.bits = {word[7:0], 1'b0, odd_parity(hist, 1'b0)};
        c.len  = DATA_LEN;
        c.hist = ^word[7:0];
      end
      CH_NULL: begin
        c.bits = {2'd0, ctrl_bits(^CODE_ESC, CODE_FCT), ctrl_bits(hist, CODE_ESC)};
        c.len  = NULL_LEN;
        c.hist = ^CODE_FCT;
      end
      default: begin
        c.bits = 10'd0;
        c.len  = 4'd0;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/tx_char_sched_if.sv
// Link-side bundle of the character scheduler: permissions, FCT and data
// handshakes, credit status and the PHY bit lines.
interface tx_char_sched_if #(
  parameter int CW = 6
);
  logic          Enable;
  logic          SendNulls;
  logic          SendFcts;
  logic          SendData;
  logic          FctReq;
  logic          FctAck;
  logic          TxValid;
  logic [8:0]    TxData;
  logic          TxReady;
  logic          FctRx;
  logic [CW-1:0] Credit;
  logic          CreditErr;
  logic          Tx1;
  logic          Tx0;
  logic          PhyReset;

  modport master (
    output Enable, SendNulls, SendFcts, SendData, FctReq, TxValid, TxData, FctRx,
    input  FctAck, TxReady, Credit, CreditErr, Tx1, Tx0, PhyReset
  );

  modport slave (
    input  Enable, SendNulls, SendFcts, SendData, FctReq, TxValid, TxData, FctRx,
    output FctAck, TxReady, Credit, CreditErr, Tx1, Tx0, PhyReset
  );
endinterface

// File: rtl/tx_credit_ctr.sv
// Peer flow-control credit: grows per received FCT, shrinks per data/EOP
// sent, refuses any update that would pass the ceiling and flags it stickily.
module tx_credit_ctr
  import tx_char_pkg::*;
#(
  parameter int CREDIT_PER_FCT = 8,
  parameter int MAX_CREDIT     = 56,
  parameter int CW             = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          fct_rx,
  input  logic          dec,
  output logic [CW-1:0] credit,
  output logic          credit_err
);

  localparam logic [CW:0] INC_C = (CW+1)'(CREDIT_PER_FCT);
  localparam logic [CW:0] MAX_C = (CW+1)'(MAX_CREDIT);

  logic [CW-1:0] credit_r;
  logic          credit_err_r;
  logic [CW:0]   next_s;
  logic          over_s;

  // Candidate credit value for this cycle and its ceiling check.
  always_comb begin
    next_s = {1'b0, credit_r};
    if (fct_rx) begin
      next_s = next_s + INC_C;
    end else begin
      next_s = next_s;
    end
    if (dec) begin
      next_s = next_s - (CW+1)'(1);
    end else begin
      next_s = next_s;
    end
    over_s = (next_s > MAX_C);
  end

  // Credit register and sticky overflow flag; clr wipes both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_r     <= {CW{1'b0}};
      credit_err_r <= 1'b0;
    end else if (clr) begin
      credit_r     <= {CW{1'b0}};
      credit_err_r <= 1'b0;
    end else if (fct_rx || dec) begin
      if (over_s) begin
        credit_err_r <= 1'b1;
      end else begin
        credit_r <= next_s[CW-1:0];
      end
    end
  end

  assign credit     = credit_r;
  assign credit_err = credit_err_r;

endmodule

// File: rtl/tx_char_sched.sv
// DS-link character transmit scheduler: picks FCT, data/EOP or NULL at each
// character boundary and shifts it out one Tx1/Tx0 bit per clock.
module tx_char_sched
  import tx_char_pkg::*;
#(
  parameter int CREDIT_PER_FCT = 8,
  parameter int MAX_CREDIT     = 56,
  parameter int CW             = 6
) (
  input  logic           TxClk,
  input  logic           TxReset_n,
  tx_char_sched_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  logic [1:0]    state_r;
  logic [9:0]    shift_r;
  logic [3:0]    cnt_r;
  logic          hist_r;
  logic          tx1_r;
  logic          tx0_r;
  logic          phy_reset_r;
  logic          fct_ack_r;
  logic          tx_ready_r;

  logic          boundary_s;
  ch_kind_e      kind_s;
  char_t         char_s;
  logic          dec_s;
  logic [CW-1:0] credit_s;
  logic          credit_err_s;

  tx_credit_ctr #(
    .CREDIT_PER_FCT (CREDIT_PER_FCT),
    .MAX_CREDIT     (MAX_CREDIT),
    .CW             (CW)
  ) u_credit (
    .clk        (TxClk),
    .rst_n      (TxReset_n),
    .clr        (~bus.Enable),
    .fct_rx     (bus.FctRx),
    .dec        (dec_s),
    .credit     (credit_s),
    .credit_err (credit_err_s)
  );

  // A boundary is any LOAD cycle, or the cycle carrying a character's last bit.
  always_comb begin
    boundary_s = 1'b0;
    if (!bus.Enable) begin
      boundary_s = 1'b0;
    end else if (state_r == ST_LOAD) begin
      boundary_s = 1'b1;
    end else if ((state_r == ST_SHIFT) && (cnt_r == 4'd0)) begin
      boundary_s = 1'b1;
    end else begin
      boundary_s = 1'b0;
    end
  end

  // Priority choice of the next character: FCT, then data/EOP, then NULL.
  always_comb begin
    kind_s = CH_NONE;
    if (!boundary_s) begin
      kind_s = CH_NONE;
    end else if (bus.SendFcts && bus.FctReq) begin
      kind_s = CH_FCT;
    end else if (bus.SendData && bus.TxValid && (credit_s != {CW{1'b0}})) begin
      kind_s = bus.TxData[8] ? CH_EOP : CH_DATA;
    end else if (bus.SendNulls) begin
      kind_s = CH_NULL;
    end else begin
      kind_s = CH_NONE;
    end
  end

  assign char_s = build_char(kind_s, bus.TxData, hist_r);
  assign dec_s  = (kind_s == CH_DATA) || (kind_s == CH_EOP);

  // Sequencer, shift register and registered PHY/handshake outputs.
  always_ff @(posedge TxClk or negedge TxReset_n) begin
    if (!TxReset_n) begin
      state_r     <= ST_IDLE;
      shift_r     <= 10'd0;
      cnt_r       <= 4'd0;
      hist_r      <= 1'b0;
      tx1_r       <= 1'b0;
      tx0_r       <= 1'b0;
      phy_reset_r <= 1'b1;
      fct_ack_r   <= 1'b0;
      tx_ready_r  <= 1'b0;
    end else if (!bus.Enable) begin
      // Abandon any partial character; it is never re-acknowledged.
      state_r     <= ST_IDLE;
      shift_r     <= 10'd0;
      cnt_r       <= 4'd0;
      hist_r      <= 1'b0;
      tx1_r       <= 1'b0;
      tx0_r       <= 1'b0;
      phy_reset_r <= 1'b1;
      fct_ack_r   <= 1'b0;
      tx_ready_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r    <= ST_LOAD;
          tx1_r      <= 1'b0;
          tx0_r      <= 1'b0;
          fct_ack_r  <= 1'b0;
          tx_ready_r <= 1'b0;
        end
        ST_LOAD, ST_SHIFT: begin
          fct_ack_r  <= (kind_s == CH_FCT);
          tx_ready_r <= dec_s;
          if (boundary_s) begin
            phy_reset_r <= 1'b0;
            if (kind_s != CH_NONE) begin
              tx1_r   <= char_s.bits[0];
              tx0_r   <= ~char_s.bits[0];
              shift_r <= {1'b0, char_s.bits[9:1]};
              cnt_r   <= char_s.len - 4'd1;
              hist_r  <= char_s.hist;
              state_r <= ST_SHIFT;
            end else begin
              tx1_r   <= 1'b0;
              tx0_r   <= 1'b0;
              state_r <= ST_LOAD;
            end
          end else begin
            tx1_r   <= shift_r[0];
            tx0_r   <= ~shift_r[0];
            shift_r <= {1'b0, shift_r[9:1]};
            cnt_r   <= cnt_r - 4'd1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          tx1_r       <= 1'b0;
          tx0_r       <= 1'b0;
          phy_reset_r <= 1'b1;
          fct_ack_r   <= 1'b0;
          tx_ready_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Tx1       = tx1_r;
  assign bus.Tx0       = tx0_r;
  assign bus.PhyReset  = phy_reset_r;
  assign bus.FctAck    = fct_ack_r;
  assign bus.TxReady   = tx_ready_r;
  assign bus.Credit    = credit_s;
  assign bus.CreditErr = credit_err_s;

endmodule

// File: tb/tb_tx_char_sched.sv
// Bench for tx_char_sched: a bit-queue reference model feeds a per-cycle
// expectation scoreboard, plus directed checks of the documented sequences.
module tb_tx_char_sched;

  logic TxClk = 1'b0;
  logic TxReset_n = 1'b0;
  always #5 TxClk = ~TxClk;

  tx_char_sched_if #(.CW(6)) bus ();

  tx_char_sched #(.CREDIT_PER_FCT(8), .MAX_CREDIT(56), .CW(6)) dut (
    .TxClk     (TxClk),
    .TxReset_n (TxReset_n),
    .bus       (bus)
  );

  typedef struct packed {
    logic       tx1;
    logic       tx0;
    logic       phy;
    logic       ack;
    logic       rdy;
    logic [5:0] credit;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: each character is a queue of wire bits built from the rules.
  bit bitq[$];
  int m_prev_ones = 0;
  int m_credit = 0;
  bit m_err = 0, m_phy = 1, m_armed = 0, m_tx1 = 0, m_tx0 = 0;

  task automatic push_char(input bit flag, input bit [7:0] payload, input int nbits);
    int ones;
    ones = m_prev_ones + int'(flag);
    bitq.push_back((ones % 2) == 0);
    bitq.push_back(flag);
    m_prev_ones = 0;
    for (int i = 0; i < nbits; i++) begin
      bitq.push_back(payload[i]);
      m_prev_ones += int'(payload[i]);
    end
  endtask

  task automatic push_ctrl(input bit c1, input bit c2);
    push_char(1'b1, {6'd0, c2, c1}, 2);
  endtask

  always @(posedge TxClk) begin : model
    exp_t e;
    bit   b, dec, ack, rdy;
    int   nc;
    ack = 0; rdy = 0; dec = 0;
    if (!TxReset_n || !bus.Enable) begin
      bitq.delete();
      m_prev_ones = 0; m_credit = 0; m_err = 0; m_phy = 1; m_armed = 0;
      m_tx1 = 0; m_tx0 = 0;
    end else begin
      if (!m_armed) begin
        m_armed = 1; m_tx1 = 0; m_tx0 = 0;
      end else begin
        if (bitq.size() == 0) begin
          m_phy = 0;
          if (bus.SendFcts && bus.FctReq) begin
            push_ctrl(0, 0); ack = 1;
          end else if (bus.SendData && bus.TxValid && m_credit > 0) begin
            rdy = 1; dec = 1;
            if (bus.TxData[8]) push_ctrl(bus.TxData[0], !bus.TxData[0]);
            else push_char(1'b0, bus.TxData[7:0], 8);
          end else if (bus.SendNulls) begin
            push_ctrl(1, 1); push_ctrl(0, 0);
          end
        end
        if (bitq.size() > 0) begin
          b = bitq.pop_front(); m_tx1 = b; m_tx0 = !b;
        end else begin
          m_tx1 = 0; m_tx0 = 0;
        end
      end
      if (bus.FctRx || dec) begin
        nc = m_credit + (bus.FctRx ? 8 : 0) - (dec ? 1 : 0);
        if (nc > 56) m_err = 1;
        else m_credit = nc;
      end
    end
    e.tx1 = m_tx1; e.tx0 = m_tx0; e.phy = m_phy; e.ack = ack; e.rdy = rdy;
    e.credit = 6'(m_credit); e.err = m_err;
    exp_q.push_back(e);
  end

  // Scoreboard monitor: one expectation per clock, compared mid-cycle.
  always @(negedge TxClk) begin : monitor
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL exp_queue: got empty expected an entry at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      chk("Tx1", int'(bus.Tx1), int'(e.tx1));
      chk("Tx0", int'(bus.Tx0), int'(e.tx0));
      chk("PhyReset", int'(bus.PhyReset), int'(e.phy));
      chk("FctAck", int'(bus.FctAck), int'(e.ack));
      chk("TxReady", int'(bus.TxReady), int'(e.rdy));
      chk("Credit", int'(bus.Credit), int'(e.credit));
      chk("CreditErr", int'(bus.CreditErr), int'(e.err));
    end
  end

  task automatic step();
    @(negedge TxClk);
    bus.FctRx = 1'b0;
    if (bus.FctAck) bus.FctReq = 1'b0;
    if (bus.TxReady) bus.TxValid = 1'b0;
  endtask

  task automatic pulse_fct_rx();
    bus.FctRx = 1'b1;
    step();
    step();
  endtask

  task automatic check_null_stream(input string name, input int nbits);
    bit [7:0] pat;
    int t;
    pat = 8'b0010_1110;
    t = 0;
    while (bus.PhyReset && t < 20) begin step(); t++; end
    chk({name, "_start"}, int'(bus.PhyReset), 0);
    for (int i = 0; i < nbits; i++) begin
      chk(name, int'(bus.Tx1), int'(pat[i % 8]));
      chk({name, "_inv"}, int'(bus.Tx0), int'(!pat[i % 8]));
      step();
    end
  endtask

  task automatic wait_ready(input string name, input int limit, output int waited);
    waited = 0;
    while (!bus.TxReady && waited < limit) begin step(); waited++; end
    chk(name, int'(bus.TxReady), 1);
  endtask

  initial begin : stim
    bit [9:0] dpat;
    int w, ack_c, rdy_c, n_ack, n_rdy;
    bus.Enable = 0; bus.SendNulls = 0; bus.SendFcts = 0; bus.SendData = 0;
    bus.FctReq = 0; bus.TxValid = 0; bus.TxData = 9'd0; bus.FctRx = 0;

    // Reset state
    @(negedge TxClk);
    chk("rst_PhyReset", int'(bus.PhyReset), 1);
    chk("rst_Tx1", int'(bus.Tx1), 0);
    chk("rst_Credit", int'(bus.Credit), 0);
    step(); step();
    TxReset_n = 1'b1;

    // NULL stream
    bus.Enable = 1; bus.SendNulls = 1;
    check_null_stream("null_bit", 24);

    // Data after NULL
    pulse_fct_rx();
    chk("credit_after_fct", int'(bus.Credit), 8);
    bus.SendData = 1; bus.TxValid = 1; bus.TxData = 9'h055;
    wait_ready("data_ready", 20, w);
    dpat = 10'b01_0101_0101;
    n_rdy = 0;
    for (int i = 0; i < 10; i++) begin
      chk("data_bit", int'(bus.Tx1), int'(dpat[i]));
      step();
      n_rdy += int'(bus.TxReady);
    end
    chk("data_ready_once", n_rdy, 0);
    chk("credit_after_data", int'(bus.Credit), 7);

    // FCT priority over pending data
    bus.SendFcts = 1;
    bus.FctReq = 1; bus.TxValid = 1; bus.TxData = {1'b0, 8'($urandom)};
    ack_c = -100; rdy_c = -50; n_ack = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.FctAck) begin ack_c = i; n_ack++; end
      if (bus.TxReady) rdy_c = i;
    end
    chk("fct_ack_count", n_ack, 1);
    chk("fct_then_data_gap", rdy_c - ack_c, 4);

    // Credit overflow
    bus.SendData = 0;
    bus.Enable = 0; step(); step();
    bus.Enable = 1; step();
    for (int i = 0; i < 7; i++) pulse_fct_rx();
    chk("credit_full", int'(bus.Credit), 56);
    chk("credit_err_clear", int'(bus.CreditErr), 0);
    pulse_fct_rx();
    chk("credit_sat", int'(bus.Credit), 56);
    chk("credit_err_set", int'(bus.CreditErr), 1);
    bus.Enable = 0; step();
    chk("disable_credit", int'(bus.Credit), 0);
    chk("disable_err", int'(bus.CreditErr), 0);

    // Abort mid data character
    bus.Enable = 1; bus.SendData = 1; step();
    pulse_fct_rx();
    bus.TxValid = 1; bus.TxData = {1'b0, 8'($urandom)};
    wait_ready("abort_ready", 30, w);
    repeat (4) step();
    bus.Enable = 0;
    step();
    chk("abort_Tx1", int'(bus.Tx1), 0);
    chk("abort_Tx0", int'(bus.Tx0), 0);
    chk("abort_PhyReset", int'(bus.PhyReset), 1);
    step(); step();
    bus.Enable = 1;
    check_null_stream("reenable_null", 8);

    // Zero-credit block
    bus.TxValid = 1; bus.TxData = {1'b0, 8'($urandom)};
    n_rdy = 0;
    for (int i = 0; i < 30; i++) begin step(); n_rdy += int'(bus.TxReady); end
    chk("zero_credit_no_ready", n_rdy, 0);
    bus.FctRx = 1; step();
    wait_ready("credit_unblocks", 12, w);

    // Randomised traffic
    for (int i = 0; i < 4000; i++) begin
      step();
      if (bus.Enable && $urandom_range(0, 199) == 0) bus.Enable = 0;
      else if (!bus.Enable && $urandom_range(0, 3) == 0) bus.Enable = 1;
      if ($urandom_range(0, 63) == 0) bus.SendNulls = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 63) == 0) bus.SendFcts = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 63) == 0) bus.SendData = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 11) == 0) bus.FctRx = 1;
      if (!bus.FctReq && $urandom_range(0, 39) == 0) bus.FctReq = 1;
      else if (bus.FctReq && $urandom_range(0, 99) == 0) bus.FctReq = 0;
      if (!bus.TxValid && $urandom_range(0, 5) == 0) begin
        bus.TxValid = 1;
        bus.TxData = 9'($urandom);
      end
    end
    step(); step();
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
